// File: rtl/cp0_intr_unit_if.sv
// Controller <-> CP0 bus: EXE-stage cp_oper stream, mfc0/mtc0 ports, interrupt gate and PC redirect.
interface cp0_intr_unit_if;
    logic        exe_valid;
    logic [1:0]  oper;
    logic [4:0]  addr_r;
    logic [31:0] data_r;
    logic [4:0]  addr_w;
    logic [31:0] data_w;
    logic [31:0] ret_addr;
    logic        ir_en;
    logic        jump_en;
    logic [31:0] jump_addr;

    modport master (
        output exe_valid, oper, addr_r, addr_w, data_w, ret_addr, ir_en,
        input  data_r, jump_en, jump_addr
    );

    modport slave (
        input  exe_valid, oper, addr_r, addr_w, data_w, ret_addr, ir_en,
        output data_r, jump_en, jump_addr
    );
endinterface

// File: rtl/cp0_intr_unit.sv
// CP0 register file, external interrupt synchroniser and IDLE/IN_HANDLER redirect FSM.
// Optional COUNT/COMPARE timer enabled by defining CP0_COUNT_EN.
module cp0_intr_unit #(
    parameter logic [31:0] EHBR_RESET  = 32'h0000_0008,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ir_in,
    cp0_intr_unit_if.slave bus
);
    localparam logic [4:0] IDX_COUNT   = 5'd9;
    localparam logic [4:0] IDX_COMPARE = 5'd11;
    localparam logic [4:0] IDX_SR      = 5'd12;
    localparam logic [4:0] IDX_CAUSE   = 5'd13;
    localparam logic [4:0] IDX_EPC     = 5'd14;
    localparam logic [4:0] IDX_EHBR    = 5'd25;
    localparam logic [1:0] OP_STORE    = 2'd1;
    localparam logic [1:0] OP_ERET     = 2'd2;

    typedef enum logic {IDLE, IN_HANDLER} state_t;

    state_t                 state, state_next;
    logic [31:0]            regs [32];
    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_prev;
    logic                   ext_pend, timer_pend;
    logic [1:0]             cause;
    logic                   store, eret, busy, take, ext_rise, timer_hit, wr_ok;
    logic                   jump_en_c;
    logic [31:0]            jump_addr_c, data_r_c;

    assign store    = bus.exe_valid && (bus.oper == OP_STORE);
    assign eret     = bus.exe_valid && (bus.oper == OP_ERET);
    assign busy     = bus.exe_valid && (bus.oper != 2'd0);
    assign cause    = {timer_pend, ext_pend};
    assign ext_rise = sync_ff[SYNC_STAGES-1] && !sync_prev;
    assign take     = (state == IDLE) && regs[IDX_SR][0] && bus.ir_en && (|cause) && !busy;

    // Index 0 and CAUSE are never stored; without the timer, COUNT/COMPARE stay at zero too.
    always_comb begin
        wr_ok = (bus.addr_w != 5'd0) && (bus.addr_w != IDX_CAUSE);
`ifdef CP0_COUNT_EN
        timer_hit = (regs[IDX_COUNT] == regs[IDX_COMPARE]) && (regs[IDX_COMPARE] != 32'd0);
`else
        wr_ok     = wr_ok && (bus.addr_w != IDX_COUNT) && (bus.addr_w != IDX_COMPARE);
        timer_hit = 1'b0;
`endif
    end

    always_comb begin
        data_r_c = regs[bus.addr_r];
        if (bus.addr_r == IDX_CAUSE)
            data_r_c = {30'd0, cause};
        if (store && wr_ok && (bus.addr_w == bus.addr_r))
            data_r_c = bus.data_w;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff   <= '0;
            sync_prev <= 1'b0;
        end else begin
            sync_ff   <= {sync_ff[SYNC_STAGES-2:0], ir_in};
            sync_prev <= sync_ff[SYNC_STAGES-1];
        end
    end

    // A fresh event in the take cycle survives the clear so it is not lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_pend   <= 1'b0;
            timer_pend <= 1'b0;
        end else begin
            if (ext_rise)
                ext_pend <= 1'b1;
            else if (take)
                ext_pend <= 1'b0;
`ifdef CP0_COUNT_EN
            if (store && (bus.addr_w == IDX_COMPARE))
                timer_pend <= 1'b0;
            else if (timer_hit)
                timer_pend <= 1'b1;
            else if (take)
                timer_pend <= 1'b0;
`else
            timer_pend <= 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= 32'd0;
            regs[IDX_EHBR] <= EHBR_RESET;
        end else begin
`ifdef CP0_COUNT_EN
            regs[IDX_COUNT] <= regs[IDX_COUNT] + 32'd1;
`endif
            if (store && wr_ok)
                regs[bus.addr_w] <= bus.data_w;
            if (take)
                regs[IDX_EPC] <= bus.ret_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next  = state;
        jump_en_c   = 1'b0;
        jump_addr_c = 32'd0;
        if (!rst) begin
            if (take) begin
                jump_en_c   = 1'b1;
                jump_addr_c = regs[IDX_EHBR];
                state_next  = IN_HANDLER;
            end else if (eret) begin
                jump_en_c   = 1'b1;
                jump_addr_c = regs[IDX_EPC];
                state_next  = IDLE;
            end
        end
    end

    assign bus.jump_en   = jump_en_c;
    assign bus.jump_addr = jump_addr_c;
    assign bus.data_r    = data_r_c;
endmodule

// File: tb/tb_cp0_intr_unit.sv
// Directed plus randomized bench for cp0_intr_unit against a cycle-level CP0 reference model.
// Timer checks are included when CP0_COUNT_EN is defined.
module tb_cp0_intr_unit;
    localparam int          SYNC     = 2;
    localparam logic [31:0] EHBR_RST = 32'h0000_0008;
`ifdef CP0_COUNT_EN
    localparam bit COUNT_EN = 1'b1;
`else
    localparam bit COUNT_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic ir_in = 1'b0;

    always #5 clk = ~clk;

    cp0_intr_unit_if bus();

    cp0_intr_unit #(.EHBR_RESET(EHBR_RST), .SYNC_STAGES(SYNC)) dut (
        .clk   (clk),
        .rst   (rst),
        .ir_in (ir_in),
        .bus   (bus)
    );

    int tests_run  = 0;
    int fail_count = 0;

    logic [31:0] m_reg [32];
    logic        m_ext, m_timer, m_in_handler;
    logic        ir_hist [$];

    function automatic logic mWritable(input logic [4:0] idx);
        if (idx == 5'd0 || idx == 5'd13) return 1'b0;
        if (!COUNT_EN && (idx == 5'd9 || idx == 5'd11)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] mRead(input logic [4:0] idx);
        if (idx == 5'd13) return {30'd0, m_timer, m_ext};
        if (!mWritable(idx)) return 32'd0;
        return m_reg[idx];
    endfunction

    function automatic logic mTake();
        return !m_in_handler && m_reg[12][0] && bus.ir_en && (m_ext || m_timer)
               && !(bus.exe_valid && bus.oper != 2'd0);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
        m_reg[25]    = EHBR_RST;
        m_ext        = 1'b0;
        m_timer      = 1'b0;
        m_in_handler = 1'b0;
        ir_hist.delete();
        for (int i = 0; i <= SYNC; i++) ir_hist.push_back(1'b0);
    endtask

    // Advance the reference model by one clock edge using the inputs currently applied.
    task automatic modelEdge();
        logic take, eret, store, rise, hit;
        if (rst) begin
            modelReset();
            return;
        end
        take  = mTake();
        eret  = bus.exe_valid && bus.oper == 2'd2;
        store = bus.exe_valid && bus.oper == 2'd1;
        rise  = ir_hist[SYNC-1] && !ir_hist[SYNC];
        hit   = COUNT_EN && (m_reg[9] == m_reg[11]) && (m_reg[11] != 32'd0);
        if (rise) m_ext = 1'b1;
        else if (take) m_ext = 1'b0;
        if (COUNT_EN && store && bus.addr_w == 5'd11) m_timer = 1'b0;
        else if (hit) m_timer = 1'b1;
        else if (take) m_timer = 1'b0;
        if (COUNT_EN) m_reg[9] = m_reg[9] + 32'd1;
        if (store && mWritable(bus.addr_w)) m_reg[bus.addr_w] = bus.data_w;
        if (take) begin
            m_reg[14]    = bus.ret_addr;
            m_in_handler = 1'b1;
        end else if (eret) begin
            m_in_handler = 1'b0;
        end
        ir_hist.push_front(ir_in);
        void'(ir_hist.pop_back());
    endtask

    task automatic expectEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic        t, e, en;
        logic [31:0] ea, ed;
        t  = mTake();
        e  = bus.exe_valid && bus.oper == 2'd2;
        en = !rst && (t || e);
        ea = rst ? 32'd0 : t ? m_reg[25] : e ? m_reg[14] : 32'd0;
        expectEq({tag, ".jump_en"}, {31'd0, bus.jump_en}, {31'd0, en});
        expectEq({tag, ".jump_addr"}, bus.jump_addr, ea);
        if (!rst) begin
            if (bus.exe_valid && bus.oper == 2'd1 && mWritable(bus.addr_w) && bus.addr_w == bus.addr_r)
                ed = bus.data_w;
            else
                ed = mRead(bus.addr_r);
            expectEq({tag, ".data_r"}, bus.data_r, ed);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic r, input logic ev, input logic [1:0] op,
                                 input logic [4:0] ar, input logic [4:0] aw, input logic [31:0] dw,
                                 input logic [31:0] ra, input logic ie, input logic irq);
        rst           = r;
        bus.exe_valid = ev;
        bus.oper      = op;
        bus.addr_r    = ar;
        bus.addr_w    = aw;
        bus.data_w    = dw;
        bus.ret_addr  = ra;
        bus.ir_en     = ie;
        ir_in         = irq;
        #1;
        checkOutput(tag);
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    initial begin
        logic [4:0]  pool [8];
        logic        r_rst, r_ev, r_ie, r_irq;
        logic [1:0]  r_op;
        logic [4:0]  r_ar, r_aw;
        logic [31:0] r_dw, r_ra;

        pool = '{5'd0, 5'd7, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd25};
        bus.exe_valid = 1'b0;
        bus.oper      = 2'd0;
        bus.addr_r    = 5'd0;
        bus.addr_w    = 5'd0;
        bus.data_w    = 32'd0;
        bus.ret_addr  = 32'd0;
        bus.ir_en     = 1'b0;
        rst           = 1'b1;
        modelReset();
        @(negedge clk);

        applyStimulus("rst0", 1, 0, 2'd0, 5'd0, 5'd0, 32'd0, 32'd0, 0, 0);
        tick();
        applyStimulus("rst_eret", 1, 1, 2'd2, 5'd25, 5'd0, 32'd0, 32'd0, 1, 0);
        expectEq("rst.jump_en", {31'd0, bus.jump_en}, 32'd0);
        expectEq("rst.jump_addr", bus.jump_addr, 32'd0);
        tick();

        applyStimulus("rd_ehbr", 0, 0, 2'd0, 5'd25, 5'd0, 32'd0, 32'd0, 0, 0);
        expectEq("rd_ehbr.val", bus.data_r, 32'h8);
        expectEq("rd_ehbr.jump_en", {31'd0, bus.jump_en}, 32'd0);
        tick();
        applyStimulus("rd_epc", 0, 0, 2'd0, 5'd14, 5'd0, 32'd0, 32'd0, 0, 0);
        expectEq("rd_epc.val", bus.data_r, 32'h0);
        tick();

        applyStimulus("wr_sr", 0, 1, 2'd1, 5'd12, 5'd12, 32'd1, 32'h40, 1, 0);
        expectEq("wr_sr.bypass", bus.data_r, 32'd1);
        tick();

        for (int i = 0; i < 3; i++) begin
            applyStimulus("irq_sync", 0, 0, 2'd0, 5'd13, 5'd0, 32'd0, 32'h40, 1, (i == 0));
            expectEq("irq_sync.jump_en", {31'd0, bus.jump_en}, 32'd0);
            expectEq("irq_sync.cause", bus.data_r, 32'd0);
            tick();
        end
        applyStimulus("take1", 0, 0, 2'd0, 5'd13, 5'd0, 32'd0, 32'h40, 1, 0);
        expectEq("take1.jump_en", {31'd0, bus.jump_en}, 32'd1);
        expectEq("take1.jump_addr", bus.jump_addr, 32'h8);
        expectEq("take1.cause", bus.data_r, 32'd1);
        tick();
        applyStimulus("after_take", 0, 0, 2'd0, 5'd14, 5'd0, 32'd0, 32'h40, 1, 0);
        expectEq("after_take.jump_en", {31'd0, bus.jump_en}, 32'd0);
        expectEq("after_take.epc", bus.data_r, 32'h40);
        tick();
        applyStimulus("after_take_cause", 0, 0, 2'd0, 5'd13, 5'd0, 32'd0, 32'h40, 1, 0);
        expectEq("after_take.cause", bus.data_r, 32'd0);
        tick();

        for (int i = 0; i < 4; i++) begin
            applyStimulus("in_handler", 0, 0, 2'd0, 5'd13, 5'd0, 32'd0, 32'h40, 1, (i == 0));
            expectEq("in_handler.jump_en", {31'd0, bus.jump_en}, 32'd0);
            tick();
        end
        applyStimulus("pend_held", 0, 0, 2'd0, 5'd13, 5'd0, 32'd0, 32'h80, 1, 0);
        expectEq("pend_held.cause", bus.data_r, 32'd1);
        expectEq("pend_held.jump_en", {31'd0, bus.jump_en}, 32'd0);
        tick();
        applyStimulus("eret1", 0, 1, 2'd2, 5'd13, 5'd0, 32'd0, 32'h80, 1, 0);
        expectEq("eret1.jump_en", {31'd0, bus.jump_en}, 32'd1);
        expectEq("eret1.jump_addr", bus.jump_addr, 32'h40);
        tick();
        applyStimulus("take2", 0, 0, 2'd0, 5'd13, 5'd0, 32'd0, 32'h80, 1, 0);
        expectEq("take2.jump_en", {31'd0, bus.jump_en}, 32'd1);
        expectEq("take2.jump_addr", bus.jump_addr, 32'h8);
        tick();
        applyStimulus("eret2", 0, 1, 2'd2, 5'd14, 5'd0, 32'd0, 32'h80, 1, 0);
        expectEq("eret2.jump_addr", bus.jump_addr, 32'h80);
        tick();

        applyStimulus("sr_clr", 0, 1, 2'd1, 5'd12, 5'd12, 32'd0, 32'h80, 1, 1);
        expectEq("sr_clr.bypass", bus.data_r, 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus("sr_clr_wait", 0, 0, 2'd0, 5'd13, 5'd0, 32'd0, 32'h80, 1, 0);
            expectEq("sr_clr_wait.jump_en", {31'd0, bus.jump_en}, 32'd0);
            tick();
        end
        applyStimulus("sr_clr_hold", 0, 0, 2'd0, 5'd13, 5'd0, 32'd0, 32'h80, 1, 0);
        expectEq("sr_clr_hold.cause", bus.data_r, 32'd1);
        expectEq("sr_clr_hold.jump_en", {31'd0, bus.jump_en}, 32'd0);
        tick();
        applyStimulus("sr_set", 0, 1, 2'd1, 5'd13, 5'd12, 32'd1, 32'h80, 1, 0);
        expectEq("sr_set.jump_en", {31'd0, bus.jump_en}, 32'd0);
        tick();
        applyStimulus("take3", 0, 0, 2'd0, 5'd13, 5'd0, 32'd0, 32'h80, 1, 0);
        expectEq("take3.jump_en", {31'd0, bus.jump_en}, 32'd1);
        expectEq("take3.jump_addr", bus.jump_addr, 32'h8);
        tick();
        applyStimulus("eret3", 0, 1, 2'd2, 5'd0, 5'd0, 32'd0, 32'h80, 1, 0);
        expectEq("eret3.jump_addr", bus.jump_addr, 32'h80);
        tick();

        applyStimulus("wr7", 0, 1, 2'd1, 5'd7, 5'd7, 32'hDEAD_BEEF, 32'h0, 1, 0);
        expectEq("wr7.bypass", bus.data_r, 32'hDEAD_BEEF);
        tick();
        applyStimulus("rd7", 0, 0, 2'd0, 5'd7, 5'd0, 32'd0, 32'h0, 1, 0);
        expectEq("rd7.val", bus.data_r, 32'hDEAD_BEEF);
        tick();
        applyStimulus("wr0", 0, 1, 2'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h0, 1, 0);
        expectEq("wr0.val", bus.data_r, 32'd0);
        tick();
        applyStimulus("rd0", 0, 0, 2'd0, 5'd0, 5'd0, 32'd0, 32'h0, 1, 0);
        expectEq("rd0.val", bus.data_r, 32'd0);
        tick();
        applyStimulus("wr_cause", 0, 1, 2'd1, 5'd13, 5'd13, 32'd3, 32'h0, 1, 0);
        expectEq("wr_cause.val", bus.data_r, 32'd0);
        tick();
        applyStimulus("op3", 0, 1, 2'd3, 5'd7, 5'd7, 32'd0, 32'h0, 1, 0);
        expectEq("op3.jump_en", {31'd0, bus.jump_en}, 32'd0);
        tick();
        applyStimulus("rd7b", 0, 0, 2'd0, 5'd7, 5'd0, 32'd0, 32'h0, 1, 0);
        expectEq("rd7b.val", bus.data_r, 32'hDEAD_BEEF);
        tick();

`ifdef CP0_COUNT_EN
        applyStimulus("wr_cmp", 0, 1, 2'd1, 5'd11, 5'd11, 32'd5, 32'h0, 1, 0);
        tick();
        applyStimulus("wr_cnt", 0, 1, 2'd1, 5'd9, 5'd9, 32'd0, 32'h0, 1, 0);
        expectEq("wr_cnt.bypass", bus.data_r, 32'd0);
        tick();
        for (int k = 0; k < 6; k++) begin
            applyStimulus("count_run", 0, 0, 2'd0, 5'd9, 5'd0, 32'd0, 32'h0, 1, 0);
            expectEq("count_run.val", bus.data_r, k);
            expectEq("count_run.jump_en", {31'd0, bus.jump_en}, 32'd0);
            tick();
        end
        applyStimulus("timer_take", 0, 0, 2'd0, 5'd13, 5'd0, 32'd0, 32'h0, 1, 0);
        expectEq("timer_take.cause", bus.data_r, 32'd2);
        expectEq("timer_take.jump_en", {31'd0, bus.jump_en}, 32'd1);
        expectEq("timer_take.jump_addr", bus.jump_addr, 32'h8);
        tick();
        applyStimulus("eret4", 0, 1, 2'd2, 5'd0, 5'd0, 32'd0, 32'h0, 0, 0);
        tick();
        applyStimulus("wr_cnt2", 0, 1, 2'd1, 5'd9, 5'd9, 32'd0, 32'h0, 0, 0);
        tick();
        for (int k = 0; k < 6; k++) begin
            applyStimulus("count_run2", 0, 0, 2'd0, 5'd9, 5'd0, 32'd0, 32'h0, 0, 0);
            tick();
        end
        applyStimulus("timer_pend", 0, 0, 2'd0, 5'd13, 5'd0, 32'd0, 32'h0, 0, 0);
        expectEq("timer_pend.cause", bus.data_r, 32'd2);
        expectEq("timer_pend.jump_en", {31'd0, bus.jump_en}, 32'd0);
        tick();
        applyStimulus("wr_cmp2", 0, 1, 2'd1, 5'd13, 5'd11, 32'd100, 32'h0, 0, 0);
        tick();
        applyStimulus("timer_clr", 0, 0, 2'd0, 5'd13, 5'd0, 32'd0, 32'h0, 0, 0);
        expectEq("timer_clr.cause", bus.data_r, 32'd0);
        tick();
`else
        applyStimulus("wr_cnt_off", 0, 1, 2'd1, 5'd9, 5'd9, 32'h1234, 32'h0, 1, 0);
        expectEq("wr_cnt_off.val", bus.data_r, 32'd0);
        tick();
        applyStimulus("rd_cnt_off", 0, 0, 2'd0, 5'd9, 5'd0, 32'd0, 32'h0, 1, 0);
        expectEq("rd_cnt_off.val", bus.data_r, 32'd0);
        tick();
`endif

        r_irq = 1'b0;
        for (int n = 0; n < 400; n++) begin
            r_rst = ($urandom_range(0, 59) == 0);
            r_ev  = $urandom_range(0, 1);
            r_op  = 2'($urandom_range(0, 3));
            r_ar  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : pool[$urandom_range(0, 7)];
            r_aw  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : pool[$urandom_range(0, 7)];
            r_dw  = (r_aw == 5'd9 || r_aw == 5'd11) ? 32'($urandom_range(0, 40)) : $urandom;
            r_ra  = $urandom;
            r_ie  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 5) == 0) r_irq = !r_irq;
            applyStimulus($sformatf("rand%0d", n), r_rst, r_ev, r_op, r_ar, r_aw, r_dw, r_ra, r_ie, r_irq);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end
endmodule

// File: doc/cp0_intr_unit.md
Name: cp0_intr_unit

Overview:
Coprocessor-0 responder for the 5-stage pipelined MIPS CPU. Consumes the controller's EXE-stage cp_oper stream (mfc0 read, mtc0 store, eret), holds the CP0 registers, and synchronises the external interrupt line. It drives jump_en/jump_addr back to the controller, which flushes ID and redirects the PC on interrupt entry and on ERET.

Parameters:
EHBR_RESET, 32'h0000_0008, reset value of the handler base register (interrupt entry address).
SYNC_STAGES, 2, flip-flop depth of the ir_in synchroniser (minimum 2).

Ports:
clk  in  1  main clock
rst  in  1  synchronous reset, active-high
exe_valid  in  1  EXE stage holds a valid instruction; oper is ignored when 0
oper  in  2  CP0 operation: 0 NONE, 1 STORE (mtc0), 2 ERET, 3 reserved (treated as NONE)
addr_r  in  5  CP0 register index for mfc0
data_r  out  32  CP0 read data (combinational)
addr_w  in  5  CP0 register index for mtc0
data_w  in  32  mtc0 write data
ret_addr  in  32  resume PC supplied by the pipeline, captured into EPC on interrupt entry
ir_en  in  1  controller global interrupt gate
ir_in  in  1  external interrupt request (asynchronous level)
jump_en  out  1  one-cycle redirect request (combinational)
jump_addr  out  32  redirect target, valid when jump_en=1

Behaviour:
- Registers: 12 SR (bit0 IE, other bits plain storage); 13 CAUSE (bit0 ext pending, bit1 timer pending; read-only, writes ignored); 14 EPC; 25 EHBR. All other indices are plain 32-bit storage; index 0 reads 0, writes ignored.
- Reset values: all registers 0 except EHBR=EHBR_RESET; synchroniser flops 0; pending 0; state IDLE. jump_en=0 and jump_addr=0 during the rst cycle.
- mtc0: exe_valid && oper==1 writes data_w to addr_w at the clock edge.
- data_r: returns reg[addr_r]. A same-cycle mtc0 to the same index bypasses, so data_r = data_w.
- Interrupt input: ir_in passes through SYNC_STAGES flops. A rising edge of the synchronised signal sets CAUSE[0]. Edges arriving while pending is already set merge into it.
- FSM states: IDLE and IN_HANDLER.
- take = state==IDLE && SR.IE && ir_en && |CAUSE[1:0] && !(exe_valid && oper!=0). The pending input is registered, so there is no combinational path from ir_in to jump_en.
- On take: jump_en=1, jump_addr=EHBR. At the edge: EPC<=ret_addr, CAUSE pending bits cleared, state->IN_HANDLER.
- ERET (exe_valid && oper==2): jump_en=1, jump_addr=EPC. At the edge: state->IDLE.
  - ERET issued in IDLE also redirects to EPC; state stays IDLE.
- ERET and take in the same cycle cannot both occur, because take is blocked while oper!=0. A pending interrupt is taken at the earliest in the cycle after ERET.
- No nesting: pending bits that set while IN_HANDLER stay set and are taken after ERET, if IE and ir_en allow.
- mtc0 clearing SR.IE blocks take in that cycle (oper!=0) and thereafter.
- rst in any state returns to reset values next edge, regardless of a simultaneous oper or take.
- Every cycle with jump_en=1 is exactly one cycle long unless the next cycle independently qualifies.

Optional Feature:
CP0_COUNT_EN.
- Defined:
  - Reg 9 COUNT increments by 1 every non-reset cycle and wraps at 2^32. An mtc0 to COUNT overrides the increment that cycle.
  - Reg 11 COMPARE: when COUNT==COMPARE and COMPARE!=0, CAUSE[1] sets at the next edge.
  - An mtc0 to COMPARE clears CAUSE[1].
- Undefined: regs 9 and 11 read 0, writes are ignored, and CAUSE[1] is always 0.

Test Plan:
- Reset, then read addr 25 -> data_r=32'h8. Read addr 14 -> 0. jump_en=0.
- mtc0 SR=1; ir_en=1; ret_addr=32'h40. Pulse ir_in for 1 cycle -> after SYNC_STAGES+1 cycles CAUSE[0]=1, then jump_en=1 with jump_addr=32'h8 for exactly one cycle. After that: EPC=32'h40, CAUSE=0, state IN_HANDLER.
- From IN_HANDLER, pulse ir_in again, then issue ERET -> ERET cycle has jump_addr=32'h40. The next cycle takes the pending interrupt, jump_addr=32'h8.
- mtc0 SR=0 while ir_in is pulsed -> CAUSE[0]=1 but no jump_en. Then mtc0 SR=1 -> jump_en is asserted the cycle after the store.
- mtc0 to addr 7 with 32'hDEAD_BEEF and addr_r=7 in the same cycle -> data_r=32'hDEAD_BEEF. mtc0 to addr 0 -> reads 0.
- CP0_COUNT_EN defined: write COUNT=0 and COMPARE=5 with SR=1 and ir_en=1 -> CAUSE[1] sets when COUNT reaches 5, then jump_en to EHBR follows. A subsequent mtc0 to COMPARE clears CAUSE[1].
